// File: rtl/cosh_sched_pkg.sv
// Shared types and constants for the cosh(x) engine scheduler.
//   XW  : default operand width
//   RW  : default result width
//   WDW : watchdog counter width (limits TMO to 1..255)
//   state_t : scheduler FSM states
package cosh_sched_pkg;

    localparam int XW  = 16;
    localparam int RW  = 32;
    localparam int WDW = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_GO,
        WAIT_DONE,
        DELIVER
    } state_t;

endpackage

// File: rtl/cosh_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req : per-client request vector
//   ptr : index with highest priority this round
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted client
//   any : at least one request is pending
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    assign any = |req;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester at or above ptr (wrapping) is the last, winning, write.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
            end
        end
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cosh_scheduler.sv
// cosh_scheduler: shares one cosh(x) series engine among N requesters.
// Grants round-robin, launches the engine with a one-cycle start pulse,
// follows the engine's ready handshake and returns the result (or a
// watchdog error) to the owner with a one-cycle done pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req[N], x_in[N*XW]  client requests and operands
//   ack[N]              one-hot pulse, operand latched
//   done, res, res_id, err   completion pulse, result, owner, timeout flag
//   eng_start, eng_x    engine launch pulse and operand
//   eng_ready, eng_busy, eng_res   engine status and result
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for a request while the engine is ready
// LAUNCH    | start pulse and ack to the winner, advance pointer
// WAIT_GO   | waiting for the engine to drop ready
// WAIT_DONE | engine busy, waiting for ready to return
// DELIVER   | done pulse with result or timeout error
module cosh_scheduler #(
    parameter int N   = 4,
    parameter int XW  = cosh_sched_pkg::XW,
    parameter int RW  = cosh_sched_pkg::RW,
    parameter int TMO = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*XW-1:0]      x_in,
    output logic [N-1:0]         ack,
    output logic                 done,
    output logic [RW-1:0]        res,
    output logic [$clog2(N)-1:0] res_id,
    output logic                 err,
    output logic                 eng_start,
    output logic [XW-1:0]        eng_x,
    input  logic                 eng_ready,
    input  logic                 eng_busy,
    input  logic [RW-1:0]        eng_res
);

    import cosh_sched_pkg::*;

    localparam int IW = $clog2(N);
    localparam logic [WDW-1:0] TMO_W = WDW'(TMO);

    state_t         state, state_nx;
    logic [IW-1:0]  ptr, ptr_nx;
    logic [IW-1:0]  owner, own_nx;
    logic [WDW-1:0] wd, wd_nx;
    logic [N-1:0]   ack_nx;
    logic           start_nx, done_nx, err_nx;
    logic [XW-1:0]  x_nx;
    logic [RW-1:0]  res_nx;
    logic [IW-1:0]  id_nx;

    logic [N-1:0]   pick_gnt;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;

    // The engine's busy flag is informational; ready alone sequences the job.
    logic unused_busy;
    assign unused_busy = eng_busy;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        own_nx   = owner;
        wd_nx    = wd;
        ack_nx   = '0;
        start_nx = 1'b0;
        done_nx  = 1'b0;
        x_nx     = eng_x;
        res_nx   = res;
        id_nx    = res_id;
        err_nx   = err;
        case (state)
            IDLE: begin
                // A low eng_ready here means an abandoned job is still draining.
                if (pick_any && eng_ready) begin
                    x_nx     = x_in[int'(pick_idx)*XW +: XW];
                    own_nx   = pick_idx;
                    ack_nx   = pick_gnt;
                    start_nx = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                ptr_nx   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
                wd_nx    = '0;
                state_nx = WAIT_GO;
            end
            WAIT_GO: begin
                wd_nx = wd + 1'b1;
                if (wd == TMO_W) begin
                    res_nx   = '0;
                    err_nx   = 1'b1;
                    id_nx    = owner;
                    done_nx  = 1'b1;
                    state_nx = DELIVER;
                end else if (!eng_ready) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wd_nx = wd + 1'b1;
                if (eng_ready) begin
                    res_nx   = eng_res;
                    err_nx   = 1'b0;
                    id_nx    = owner;
                    done_nx  = 1'b1;
                    state_nx = DELIVER;
                end else if (wd == TMO_W) begin
                    res_nx   = '0;
                    err_nx   = 1'b1;
                    id_nx    = owner;
                    done_nx  = 1'b1;
                    state_nx = DELIVER;
                end
            end
            DELIVER: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            owner     <= '0;
            wd        <= '0;
            ack       <= '0;
            eng_start <= 1'b0;
            done      <= 1'b0;
            eng_x     <= '0;
            res       <= '0;
            res_id    <= '0;
            err       <= 1'b0;
        end else begin
            ptr       <= ptr_nx;
            owner     <= own_nx;
            wd        <= wd_nx;
            ack       <= ack_nx;
            eng_start <= start_nx;
            done      <= done_nx;
            eng_x     <= x_nx;
            res       <= res_nx;
            res_id    <= id_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_cosh_scheduler.sv
// Directed bench for cosh_scheduler with a small behavioural engine model.
// Engine result model: res = (x << 8) + 0x800, ready low for LAT+1 cycles.
module tb_cosh_scheduler;

    localparam int N   = 4;
    localparam int XW  = 16;
    localparam int RW  = 32;
    localparam int TMO = 10;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req;
    logic [N*XW-1:0] x_in;
    logic [N-1:0]    ack;
    logic            done;
    logic [RW-1:0]   res;
    logic [1:0]      res_id;
    logic            err;
    logic            eng_start;
    logic [XW-1:0]   eng_x;
    logic            eng_ready;
    logic            eng_busy;
    logic [RW-1:0]   eng_res;

    int checks = 0;
    int errors = 0;

    logic          stuck = 1'b0;
    int            ecnt;
    logic [XW-1:0] jx;

    cosh_scheduler #(.N(N), .XW(XW), .RW(RW), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .ack       (ack),
        .done      (done),
        .res       (res),
        .res_id    (res_id),
        .err       (err),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_ready (eng_ready),
        .eng_busy  (eng_busy),
        .eng_res   (eng_res)
    );

    always #5 clk = ~clk;

    // Engine model; shares the reset with the scheduler.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_ready <= 1'b1;
            eng_busy  <= 1'b0;
            eng_res   <= '0;
            ecnt      <= 0;
            jx        <= '0;
        end else if (eng_start && eng_ready) begin
            eng_ready <= 1'b0;
            eng_busy  <= 1'b1;
            ecnt      <= LAT;
            jx        <= eng_x;
        end else if (!eng_ready && !stuck) begin
            if (ecnt == 0) begin
                eng_ready <= 1'b1;
                eng_busy  <= 1'b0;
                eng_res   <= {8'h00, jx, 8'h00} + 32'h0000_0800;
            end else begin
                ecnt <= ecnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_x(input int i, input logic [XW-1:0] v);
        x_in[i*XW +: XW] = v;
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] exp_ack);
        int cyc;
        cyc = 0;
        while (ack === '0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_ack"}, 64'(ack), 64'(exp_ack));
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc, output logic saw_ack);
        cyc = 0;
        saw_ack = 1'b0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack !== '0) saw_ack = 1'b1;
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic run_job(input string tag, input logic [N-1:0] exp_ack, input logic [XW-1:0] exp_x,
                           input logic [RW-1:0] exp_res, input logic [1:0] exp_id);
        int   cyc;
        logic saw;
        wait_ack(tag, exp_ack);
        chk({tag, "_start"}, 64'(eng_start), 64'(1));
        chk({tag, "_engx"}, 64'(eng_x), 64'(exp_x));
        req = req & ~exp_ack;
        wait_done(tag, 40, cyc, saw);
        chk({tag, "_res"}, 64'(res), 64'(exp_res));
        chk({tag, "_id"}, 64'(res_id), 64'(exp_id));
        chk({tag, "_err"}, 64'(err), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int   cyc;
        logic saw;

        req  = '0;
        x_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_start", 64'(eng_start), 64'(0));
        chk("rst_engx", 64'(eng_x), 64'(0));
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_id", 64'(res_id), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // All four clients request together; pointer starts at 0.
        set_x(0, 16'h0011);
        set_x(1, 16'h0022);
        set_x(2, 16'h0033);
        set_x(3, 16'h0044);
        req = 4'b1111;
        run_job("rr0", 4'b0001, 16'h0011, 32'h0000_1900, 2'd0);
        run_job("rr1", 4'b0010, 16'h0022, 32'h0000_2A00, 2'd1);
        run_job("rr2", 4'b0100, 16'h0033, 32'h0000_3B00, 2'd2);
        run_job("rr3", 4'b1000, 16'h0044, 32'h0000_4C00, 2'd3);

        // Single request with exact cycle timing.
        set_x(0, 16'h0100);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_ack", 64'(ack), 64'(4'b0001));
        chk("t1_start", 64'(eng_start), 64'(1));
        chk("t1_engx", 64'(eng_x), 64'(16'h0100));
        req = 4'b0000;
        @(negedge clk);
        chk("t1_ack_pulse", 64'(ack), 64'(0));
        chk("t1_start_pulse", 64'(eng_start), 64'(0));
        repeat (2) @(negedge clk);
        chk("t1_engx_hold", 64'(eng_x), 64'(16'h0100));
        wait_done("t1", 40, cyc, saw);
        chk("t1_latency", 64'(cyc), 64'(3));
        chk("t1_res", 64'(res), 64'(32'h0001_0800));
        chk("t1_id", 64'(res_id), 64'(0));
        chk("t1_err", 64'(err), 64'(0));
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'(0));
        chk("t1_res_hold", 64'(res), 64'(32'h0001_0800));

        // Move pointer to 3, then wrap 3 -> 0, then pointer 1 with only client 0.
        set_x(2, 16'h0021);
        req = 4'b0100;
        run_job("wr_pre", 4'b0100, 16'h0021, 32'h0000_2900, 2'd2);
        set_x(3, 16'h0031);
        set_x(0, 16'h0001);
        req = 4'b1001;
        run_job("wr3", 4'b1000, 16'h0031, 32'h0000_3900, 2'd3);
        run_job("wr0", 4'b0001, 16'h0001, 32'h0000_0900, 2'd0);
        set_x(0, 16'h0002);
        req = 4'b0001;
        run_job("wr_p1", 4'b0001, 16'h0002, 32'h0000_0A00, 2'd0);

        // Late request raised while a job is in WAIT_DONE.
        set_x(1, 16'h0055);
        req = 4'b0010;
        wait_ack("late_a", 4'b0010);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        set_x(2, 16'h0066);
        req = 4'b0100;
        wait_done("late_a", 40, cyc, saw);
        chk("late_no_early_ack", 64'(saw), 64'(0));
        chk("late_a_res", 64'(res), 64'(32'h0000_5D00));
        chk("late_a_id", 64'(res_id), 64'(1));
        @(negedge clk);
        chk("late_ack_p1", 64'(ack), 64'(0));
        @(negedge clk);
        chk("late_ack_p2", 64'(ack), 64'(4'b0100));
        chk("late_engx", 64'(eng_x), 64'(16'h0066));
        req = 4'b0000;
        wait_done("late_b", 40, cyc, saw);
        chk("late_b_res", 64'(res), 64'(32'h0000_6E00));
        chk("late_b_id", 64'(res_id), 64'(2));
        @(negedge clk);

        // Watchdog: engine never returns to ready.
        stuck = 1'b1;
        set_x(0, 16'h0077);
        req = 4'b0001;
        wait_ack("tmo", 4'b0001);
        req = 4'b0000;
        wait_done("tmo", 40, cyc, saw);
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_res", 64'(res), 64'(0));
        chk("tmo_id", 64'(res_id), 64'(0));
        @(negedge clk);
        set_x(1, 16'h0088);
        req = 4'b0010;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== '0 || eng_start !== 1'b0) saw = 1'b1;
        end
        chk("tmo_hold_launch", 64'(saw), 64'(0));
        stuck = 1'b0;
        run_job("tmo_next", 4'b0010, 16'h0088, 32'h0000_9000, 2'd1);

        // Reset in the middle of a job.
        set_x(2, 16'h00AB);
        set_x(3, 16'h00AA);
        req = 4'b1100;
        wait_ack("mid", 4'b0100);
        req = 4'b1000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_ack", 64'(ack), 64'(0));
        chk("mid_done", 64'(done), 64'(0));
        chk("mid_err", 64'(err), 64'(0));
        chk("mid_start", 64'(eng_start), 64'(0));
        chk("mid_engx", 64'(eng_x), 64'(0));
        chk("mid_res", 64'(res), 64'(0));
        chk("mid_id", 64'(res_id), 64'(0));
        @(negedge clk);
        chk("mid_no_done", 64'(done), 64'(0));
        set_x(0, 16'h0099);
        req = 4'b1001;
        rst = 1'b1;
        run_job("post0", 4'b0001, 16'h0099, 32'h0000_A100, 2'd0);
        run_job("post3", 4'b1000, 16'h00AA, 32'h0000_B200, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
